inst_axi_fetch: RTL
===================

Name: inst_axi_fetch

Overview:
- Instruction-fetch AXI read master that sits between the dual-issue core (IF_1/IF_2 stages) and the AXI read channel.
- For each fetch request it issues one 2-beat INCR burst at fetch_pc and returns the instruction pair for pc and pc+4 in a single cycle.
- Handles branch-redirect flushes, misaligned PCs and bus errors, and holds the result until the core accepts it.

Parameters:
- AR_ID, 4'd0, constant arid/expected rid.
- AR_CACHE, 4'd0, constant arcache value.
- AR_PROT, 3'd0, constant arprot value.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_req  input  1  core requests an instruction pair.
- fetch_pc  input  32  PC of first instruction; sampled on acceptance.
- fetch_flush  input  1  redirect; abandon the current fetch.
- fetch_busy  output  1  high in every state except IDLE.
- fetch_valid  output  1  instruction pair available.
- fetch_ready  input  1  core consumes pair when fetch_valid & fetch_ready.
- fetch_inst_1  output  32  instruction at fetch_pc_out.
- fetch_inst_2  output  32  instruction at fetch_pc_out+4.
- fetch_pc_out  output  32  PC of delivered pair.
- fetch_adel  output  1  misaligned PC exception for delivered pair.
- fetch_buserr  output  1  rresp error or burst-length violation for delivered pair.
- arvalid  output  1  AR valid.
- araddr  output  32  AR address.
- arid  output  4  = AR_ID.
- arlen  output  4  constant 4'd1 (2 beats).
- arsize  output  3  constant 3'b010.
- arburst  output  2  constant 2'b01 (INCR).
- arlock  output  2  constant 0.
- arcache  output  4  = AR_CACHE.
- arprot  output  3  = AR_PROT.
- arready  input  1  AR ready.
- rvalid  input  1  R valid.
- rid  input  4  R id.
- rdata  input  32  R data.
- rresp  input  2  R response.
- rlast  input  1  R last.
- rready  output  1  R ready.

Behaviour:

Reset (reset low, asynchronous):
- State = IDLE.
- arvalid, rready, fetch_valid, fetch_adel, fetch_buserr = 0.
- araddr, fetch_inst_1, fetch_inst_2, fetch_pc_out = 0.
- A reset asserted mid-burst abandons the transaction; the interconnect is reset together with this block.

States: IDLE, AR, R0, R1, DONE, DRAIN. All outputs are registered.

- IDLE:
  - fetch_req & !fetch_flush: latch pc into fetch_pc_out.
  - If pc[1:0] != 0: go to DONE with adel=1 and both insts = 0; no AXI traffic.
  - Otherwise: araddr = pc, arvalid = 1 next cycle, go to AR.
- AR:
  - arvalid is held until arready; it is never withdrawn early, even on flush.
  - Handshake: arvalid -> 0, rready -> 1, go to R0; go to DRAIN instead if a flush was seen while in AR (flush_pend flag).
- R0:
  - Beats are accepted only when rvalid & rid == AR_ID; beats with a mismatched rid are ignored.
  - Beat: fetch_inst_1 = rdata; buserr |= (rresp != 0).
  - If rlast = 1: buserr = 1, inst_2 = 0, go to DONE. Otherwise go to R1.
- R1:
  - Beat: fetch_inst_2 = rdata; buserr |= (rresp != 0) | !rlast.
  - Then rready = 0, fetch_valid = 1, go to DONE.
- DONE:
  - fetch_valid held with all data stable until fetch_ready.
  - On fetch_ready: if fetch_req & !fetch_flush, accept the next request in the same cycle (back-to-back, same rules as IDLE); else go to IDLE.
- Flush:
  - IDLE: request ignored.
  - AR: sets flush_pend.
  - R0/R1: go to DRAIN.
  - DONE: fetch_valid = 0 next cycle, go to IDLE.
- DRAIN:
  - rready = 1; discard beats until an accepted beat has rlast = 1, then go to IDLE.
  - New requests are not accepted while in DRAIN.
- Latency, with arready = 1 and rvalid in consecutive cycles: fetch_req at cycle 0 -> arvalid at cycle 1 -> beats at cycles 2 and 3 -> fetch_valid at cycle 4.
- Simultaneous fetch_flush and fetch_ready in DONE: flush wins and no new request is accepted.

Decomposition:
- Shared package mips_axi_pkg holds:
  - state encoding;
  - AXI_BURST_INCR = 2'b01;
  - AXI_SIZE_WORD = 3'b010;
  - AXI_RESP_OKAY = 2'b00;
  - IF_BURST_LEN = 4'd1.
- Single module; no sub-module is needed.

Test Plan:
- Aligned fetch, fetch_pc = 0xBFC00000, arready = 1, beats 0x24010001 / 0x24020002 with rlast on beat 2 -> araddr = 0xBFC00000, fetch_valid at cycle 4, inst_1 = 0x24010001, inst_2 = 0x24020002, buserr = 0.
- arready low for 3 cycles, flush pulsed at cycle 2 -> arvalid stays high until the handshake, both beats drained, fetch_valid never asserted, IDLE afterwards.
- fetch_pc = 0xBFC00002 -> no arvalid; fetch_valid next cycle with adel = 1 and insts = 0.
- Beat 2 rresp = 2'b10 -> fetch_valid with buserr = 1 and inst_2 = rdata.
- fetch_ready held low for 5 cycles in DONE -> outputs stable; on fetch_ready with a new req (pc 0xBFC00008) -> arvalid on the next cycle, araddr = 0xBFC00008.
- reset driven low between beat 1 and beat 2 -> all outputs 0 immediately and state IDLE; a fresh fetch after reset completes normally.

Source files
------------

// File: rtl/mips_axi_pkg.sv
// Shared definitions for the MIPS core's AXI masters: fetch FSM states and AXI encodings.
package mips_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R0,
        S_R1,
        S_DONE,
        S_DRAIN
    } fetch_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] IF_BURST_LEN   = 4'd1;

endpackage

// File: rtl/inst_axi_fetch.sv
// Instruction-fetch AXI read master: one 2-beat INCR burst per request, delivers the
// instruction pair (pc, pc+4) together and holds it until the core accepts it.
module inst_axi_fetch
    import mips_axi_pkg::*;
#(
    parameter logic [3:0] AR_ID    = 4'd0,
    parameter logic [3:0] AR_CACHE = 4'd0,
    parameter logic [2:0] AR_PROT  = 3'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_flush,
    output logic        fetch_busy,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_inst_1,
    output logic [31:0] fetch_inst_2,
    output logic [31:0] fetch_pc_out,
    output logic        fetch_adel,
    output logic        fetch_buserr,
    output logic        arvalid,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    output logic        rready
);

    fetch_state_t state, state_d;
    logic        flush_pend, flush_pend_d;
    logic        arvalid_d, rready_d, valid_d, adel_d, buserr_d;
    logic [31:0] araddr_d, inst1_d, inst2_d, pc_d;
    logic        beat, start;

    assign arid       = AR_ID;
    assign arlen      = IF_BURST_LEN;
    assign arsize     = AXI_SIZE_WORD;
    assign arburst    = AXI_BURST_INCR;
    assign arlock     = '0;
    assign arcache    = AR_CACHE;
    assign arprot     = AR_PROT;
    assign fetch_busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            flush_pend   <= 1'b0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
            fetch_valid  <= 1'b0;
            fetch_adel   <= 1'b0;
            fetch_buserr <= 1'b0;
            araddr       <= '0;
            fetch_inst_1 <= '0;
            fetch_inst_2 <= '0;
            fetch_pc_out <= '0;
        end else begin
            state        <= state_d;
            flush_pend   <= flush_pend_d;
            arvalid      <= arvalid_d;
            rready       <= rready_d;
            fetch_valid  <= valid_d;
            fetch_adel   <= adel_d;
            fetch_buserr <= buserr_d;
            araddr       <= araddr_d;
            fetch_inst_1 <= inst1_d;
            fetch_inst_2 <= inst2_d;
            fetch_pc_out <= pc_d;
        end
    end

    always_comb begin
        state_d      = state;
        flush_pend_d = flush_pend;
        arvalid_d    = arvalid;
        rready_d     = rready;
        valid_d      = fetch_valid;
        adel_d       = fetch_adel;
        buserr_d     = fetch_buserr;
        araddr_d     = araddr;
        inst1_d      = fetch_inst_1;
        inst2_d      = fetch_inst_2;
        pc_d         = fetch_pc_out;
        beat         = rvalid && rready && (rid == AR_ID);
        start        = 1'b0;

        case (state)
            S_IDLE: start = fetch_req && !fetch_flush;
            S_AR: begin
                // AR is never withdrawn; a flush here only redirects the burst to DRAIN
                if (fetch_flush) flush_pend_d = 1'b1;
                if (arready) begin
                    arvalid_d    = 1'b0;
                    rready_d     = 1'b1;
                    flush_pend_d = 1'b0;
                    state_d      = (flush_pend || fetch_flush) ? S_DRAIN : S_R0;
                end
            end
            S_R0: begin
                if (beat) begin
                    inst1_d  = rdata;
                    buserr_d = (rresp != AXI_RESP_OKAY) || rlast;
                    if (rlast) inst2_d = '0;
                end
                // a flushed burst whose last beat lands this cycle needs no draining
                if (fetch_flush) begin
                    if (beat && rlast) begin
                        rready_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (beat) begin
                    if (rlast) begin
                        rready_d = 1'b0;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_R1;
                    end
                end
            end
            S_R1: begin
                if (beat) begin
                    inst2_d  = rdata;
                    buserr_d = fetch_buserr || (rresp != AXI_RESP_OKAY) || !rlast;
                end
                if (fetch_flush) begin
                    if (beat && rlast) begin
                        rready_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (beat) begin
                    rready_d = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (fetch_flush) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (fetch_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                    start   = fetch_req;
                end
            end
            S_DRAIN: begin
                if (beat && rlast) begin
                    rready_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            pc_d     = fetch_pc;
            buserr_d = 1'b0;
            if (fetch_pc[1:0] != 2'b00) begin
                adel_d  = 1'b1;
                inst1_d = '0;
                inst2_d = '0;
                valid_d = 1'b1;
                state_d = S_DONE;
            end else begin
                adel_d       = 1'b0;
                araddr_d     = fetch_pc;
                arvalid_d    = 1'b1;
                flush_pend_d = 1'b0;
                valid_d      = 1'b0;
                state_d      = S_AR;
            end
        end
    end

endmodule
